// File: rtl/mesi_snoop_bus_pkg.sv
// Shared coherence types for the snooping bus: bus commands, line states
// and the bus controller's transaction phases.
package mesi_types;

   typedef enum logic [1:0] {
      No_OP   = 2'd0,
      BusRd   = 2'd1,
      BusRdX  = 2'd2,
      BusUpgr = 2'd3
   } bus_request;

   typedef enum logic [1:0] {
      INVALID   = 2'd0,
      SHARED    = 2'd1,
      EXCLUSIVE = 2'd2,
      MODIFIED  = 2'd3
   } cache_state;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BROADCAST = 2'd1,
      COLLECT   = 2'd2,
      RESPOND   = 2'd3
   } snoop_bus_state_e;

endpackage

// File: rtl/mesi_snoop_bus_arbiter.sv
// Round-robin arbiter: the search starts at the priority pointer, and the
// pointer moves to the slot just after the winner only when a grant is taken.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand_idx;
   int            cand;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any          = 1'b0;
      cand         = 0;
      cand_idx     = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         cand_idx = IW'(cand);
         if (!any && req[cand_idx]) begin
            any                    = 1'b1;
            grant_idx              = cand_idx;
            grant_onehot[cand_idx] = 1'b1;
         end
      end
   end

   // Explicit wrap compare keeps the rotation correct for non-power-of-two N.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && any) begin
         ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/mesi_snoop_bus.sv
// Snooping bus controller: serialises per-core coherence requests, broadcasts
// each one, and folds the peers' hit/dirty answers into a shared/flush reply.
module mesi_snoop_bus
   import mesi_types::*;
#(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 8,
   parameter int CORE_W    = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req_valid,
   input  logic [2*NUM_CORES-1:0]      req_cmd,
   input  logic [ADDR_W*NUM_CORES-1:0] req_addr,
   output logic [NUM_CORES-1:0]        req_ready,
   output logic                        snoop_valid,
   output bus_request                  snoop_cmd,
   output logic [ADDR_W-1:0]           snoop_addr,
   output logic [CORE_W-1:0]           snoop_src,
   input  logic [NUM_CORES-1:0]        snoop_hit,
   input  logic [NUM_CORES-1:0]        snoop_dirty,
   output logic [NUM_CORES-1:0]        resp_valid,
   output logic                        resp_shared,
   output logic                        resp_flush,
   output logic                        busy,
   output logic                        protocol_err
);

   localparam logic [1:0] S_IDLE      = IDLE;
   localparam logic [1:0] S_BROADCAST = BROADCAST;
   localparam logic [1:0] S_COLLECT   = COLLECT;
   localparam logic [1:0] S_RESPOND   = RESPOND;

   logic [1:0]           state;
   bus_request           cmd_q;
   logic [NUM_CORES-1:0] grant_q;
   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] win_onehot;
   logic [CORE_W-1:0]    win_idx;
   logic                 win_any;
   logic [NUM_CORES-1:0] hit_m;
   logic [NUM_CORES-1:0] dirty_m;

   // A core holding No_OP is treated as not requesting at all.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         eligible[i] = req_valid[i] && (req_cmd[2*i +: 2] != No_OP);
      end
   end

   rr_arbiter #(.N(NUM_CORES)) u_arb (
      .clk          (clk),
      .rst          (rst),
      .req          (eligible),
      .advance      (state == S_IDLE),
      .grant_onehot (win_onehot),
      .grant_idx    (win_idx),
      .any          (win_any)
   );

   assign hit_m   = snoop_hit & ~grant_q;
   assign dirty_m = snoop_dirty & ~grant_q;

   // Every output is a one-cycle registered pulse that defaults back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cmd_q        <= No_OP;
         grant_q      <= '0;
         req_ready    <= '0;
         snoop_valid  <= 1'b0;
         snoop_cmd    <= No_OP;
         snoop_addr   <= '0;
         snoop_src    <= '0;
         resp_valid   <= '0;
         resp_shared  <= 1'b0;
         resp_flush   <= 1'b0;
         busy         <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         req_ready    <= '0;
         snoop_valid  <= 1'b0;
         snoop_cmd    <= No_OP;
         snoop_addr   <= '0;
         snoop_src    <= '0;
         resp_valid   <= '0;
         resp_shared  <= 1'b0;
         resp_flush   <= 1'b0;
         protocol_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (win_any) begin
                  state       <= S_BROADCAST;
                  busy        <= 1'b1;
                  cmd_q       <= bus_request'(req_cmd[2*win_idx +: 2]);
                  grant_q     <= win_onehot;
                  req_ready   <= win_onehot;
                  snoop_valid <= 1'b1;
                  snoop_cmd   <= bus_request'(req_cmd[2*win_idx +: 2]);
                  snoop_addr  <= req_addr[ADDR_W*win_idx +: ADDR_W];
                  snoop_src   <= win_idx;
               end
            end
            S_BROADCAST: state <= S_COLLECT;
            S_COLLECT: begin
               // Ownership requests never leave the requester in S.
               state        <= S_RESPOND;
               resp_valid   <= grant_q;
               resp_flush   <= |dirty_m;
               resp_shared  <= (cmd_q == BusRd) && (|hit_m);
               protocol_err <= ((dirty_m & (dirty_m - NUM_CORES'(1))) != '0)
                               || (|(dirty_m & ~hit_m));
            end
            S_RESPOND: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Self-checking bench for mesi_snoop_bus: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_mesi_snoop_bus;
   import mesi_types::*;

   localparam int N  = 4;
   localparam int AW = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [2*N-1:0] req_cmd;
   logic [AW*N-1:0] req_addr;
   logic [N-1:0]   req_ready;
   logic           snoop_valid;
   bus_request     snoop_cmd;
   logic [AW-1:0]  snoop_addr;
   logic [1:0]     snoop_src;
   logic [N-1:0]   snoop_hit;
   logic [N-1:0]   snoop_dirty;
   logic [N-1:0]   resp_valid;
   logic           resp_shared;
   logic           resp_flush;
   logic           busy;
   logic           protocol_err;

   int n_compared   = 0;
   int n_mismatched = 0;
   int rr_ptr       = 0;
   int got_src;

   mesi_snoop_bus #(.NUM_CORES(N), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_cmd      (req_cmd),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .snoop_valid  (snoop_valid),
      .snoop_cmd    (snoop_cmd),
      .snoop_addr   (snoop_addr),
      .snoop_src    (snoop_src),
      .snoop_hit    (snoop_hit),
      .snoop_dirty  (snoop_dirty),
      .resp_valid   (resp_valid),
      .resp_shared  (resp_shared),
      .resp_flush   (resp_flush),
      .busy         (busy),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // The winner is the eligible core closest to the pointer going upward with wrap.
   function automatic int pickWinner(input logic [N-1:0] elig);
      int best = -1;
      int best_dist = N;
      for (int i = 0; i < N; i++) begin
         if (elig[i] && ((i - rr_ptr + N) % N) < best_dist) begin
            best_dist = (i - rr_ptr + N) % N;
            best = i;
         end
      end
      return best;
   endfunction

   task automatic randomJunk();
      snoop_hit   = 4'($urandom);
      snoop_dirty = 4'($urandom);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req_valid = 4'($urandom);
         req_cmd   = 8'($urandom);
         req_addr  = $urandom;
         randomJunk();
         @(negedge clk);
      end
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_snoop_valid", snoop_valid, 0);
      checkOutput("rst_snoop_cmd", snoop_cmd, No_OP);
      checkOutput("rst_snoop_addr", snoop_addr, 0);
      checkOutput("rst_snoop_src", snoop_src, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_shared", resp_shared, 0);
      checkOutput("rst_resp_flush", resp_flush, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_protocol_err", protocol_err, 0);
      rst = 1'b0;
      req_valid = '0;
      rr_ptr = 0;
   endtask

   // Called at the falling edge of an IDLE cycle; returns at the next IDLE falling edge.
   task automatic applyStimulus(input logic [N-1:0] valid, input logic [2*N-1:0] cmds,
                                input logic [AW*N-1:0] addrs, input logic [N-1:0] hit,
                                input logic [N-1:0] dirty, output int winner);
      logic [N-1:0] elig;
      logic [N-1:0] oh;
      logic [N-1:0] hm;
      logic [N-1:0] dm;
      logic [1:0]   c;
      logic [AW-1:0] a;
      req_valid = valid;
      req_cmd   = cmds;
      req_addr  = addrs;
      randomJunk();
      for (int i = 0; i < N; i++) elig[i] = valid[i] && (cmds[2*i +: 2] != 2'd0);
      winner = pickWinner(elig);
      if (winner < 0) begin
         @(negedge clk);
         checkOutput("nogrant_busy", busy, 0);
         checkOutput("nogrant_ready", req_ready, 0);
         return;
      end
      rr_ptr = (winner + 1) % N;
      c  = cmds[2*winner +: 2];
      a  = addrs[AW*winner +: AW];
      oh = 4'b0001 << winner;
      @(negedge clk);
      checkOutput("bcast_req_ready", req_ready, oh);
      checkOutput("bcast_snoop_valid", snoop_valid, 1);
      checkOutput("bcast_snoop_cmd", snoop_cmd, c);
      checkOutput("bcast_snoop_addr", snoop_addr, a);
      checkOutput("bcast_snoop_src", snoop_src, winner);
      checkOutput("bcast_busy", busy, 1);
      req_cmd[2*winner +: 2]  = 2'($urandom);
      req_addr[AW*winner +: AW] = ~a;
      randomJunk();
      @(negedge clk);
      checkOutput("collect_req_ready", req_ready, 0);
      checkOutput("collect_snoop_valid", snoop_valid, 0);
      snoop_hit   = hit;
      snoop_dirty = dirty;
      @(negedge clk);
      randomJunk();
      hm = hit & ~oh;
      dm = dirty & ~oh;
      checkOutput("resp_valid", resp_valid, oh);
      checkOutput("resp_shared", resp_shared, (c == 2'd1) && (hm != 0));
      checkOutput("resp_flush", resp_flush, dm != 0);
      checkOutput("protocol_err", protocol_err, ($countones(dm) > 1) || ((dm & ~hm) != 0));
      @(negedge clk);
      checkOutput("idle_resp_valid", resp_valid, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_protocol_err", protocol_err, 0);
   endtask

   initial begin
      logic [N-1:0] rv;
      logic [N-1:0] rh;
      logic [N-1:0] rd;
      int exp_order [6] = '{0, 1, 3, 0, 1, 3};
      resetDut();

      $display("[TB] single BusRd from core 2");
      applyStimulus(4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, 32'h003C_0000, 4'b0000, 4'b0000, got_src);
      checkOutput("single_src", got_src, 2);

      $display("[TB] round-robin among cores 0,1,3");
      resetDut();
      for (int t = 0; t < 6; t++) begin
         applyStimulus(4'b1011, {2'd1, 2'd1, 2'd1, 2'd1}, $urandom, 4'b0000, 4'b0000, got_src);
         checkOutput("rr_order", got_src, exp_order[t]);
      end

      $display("[TB] shared/flush combinations and protocol errors");
      applyStimulus(4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, 32'h0000_1000, 4'b0001, 4'b0001, got_src);
      applyStimulus(4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, 32'h0000_1000, 4'b0100, 4'b0000, got_src);
      applyStimulus(4'b1000, {2'd1, 2'd0, 2'd0, 2'd0}, 32'h5500_0000, 4'b1000, 4'b0000, got_src);
      applyStimulus(4'b1000, {2'd1, 2'd0, 2'd0, 2'd0}, 32'h5500_0000, 4'b0101, 4'b0101, got_src);
      applyStimulus(4'b0001, {2'd0, 2'd0, 2'd0, 2'd3}, 32'h0000_00AA, 4'b0000, 4'b0010, got_src);
      applyStimulus(4'b1111, {2'd0, 2'd0, 2'd0, 2'd0}, 32'h1234_5678, 4'b0000, 4'b0000, got_src);

      $display("[TB] reset during COLLECT");
      req_valid = 4'b0010;
      req_cmd   = {2'd0, 2'd0, 2'd1, 2'd0};
      req_addr  = 32'h0000_2200;
      @(negedge clk);
      checkOutput("midrst_started", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_resp_valid", resp_valid, 0);
      checkOutput("midrst_snoop_valid", snoop_valid, 0);
      rst = 1'b0;
      rr_ptr = 0;
      applyStimulus(4'b1001, {2'd2, 2'd0, 2'd0, 2'd1}, 32'h7700_0011, 4'b0000, 4'b0000, got_src);
      checkOutput("midrst_first_grant", got_src, 0);

      $display("[TB] random transactions");
      for (int t = 0; t < 40; t++) begin
         rv = 4'($urandom);
         rh = 4'($urandom);
         rd = (t % 5 == 0) ? 4'($urandom) : (rh & 4'($urandom));
         applyStimulus(rv, 8'($urandom), $urandom, rh, rd, got_src);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mesi_snoop_bus.md
Name: mesi_snoop_bus

Overview:
Parametrised successor to the two-cache shared bus. It serialises coherence requests from NUM_CORES private caches and broadcasts each granted request to all snoopers. It collects each snooper's hit/dirty response and returns a combined shared/flush result to the requester. That result replaces the externally driven exclusive inputs and adds fair round-robin arbitration plus protocol-error detection.

Parameters:
NUM_CORES, 4, number of caches on the bus (2..16)
ADDR_W, 8, line address width
CORE_W, $clog2(NUM_CORES), derived: core index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_CORES  per-core request pending; held until req_ready seen
req_cmd  in  bus_request x NUM_CORES  per-core command (BusRd/BusRdX/BusUpgr)
req_addr  in  ADDR_W x NUM_CORES  per-core line address
req_ready  out  NUM_CORES  one-hot, one-cycle accept pulse to the granted core
snoop_valid  out  1  broadcast strobe
snoop_cmd  out  bus_request  broadcast command
snoop_addr  out  ADDR_W  broadcast address
snoop_src  out  CORE_W  index of requesting core
snoop_hit  in  NUM_CORES  core holds line in S/E/M (valid in COLLECT cycle)
snoop_dirty  in  NUM_CORES  core holds line in M and flushes it (valid in COLLECT)
resp_valid  out  NUM_CORES  one-hot, one-cycle response to the requester
resp_shared  out  1  requester installs S (1) or E/M (0)
resp_flush  out  1  a peer supplied dirty data
busy  out  1  transaction in flight (state != IDLE)
protocol_err  out  1  one-cycle pulse on illegal snoop response

Behaviour:
- All state and outputs are registered. Reset values: every output 0, snoop_cmd = No_OP, state IDLE, rr pointer 0.
- Eligible requesters: req_valid[i] && req_cmd[i] != No_OP. A No_OP request is ignored and is never granted.
- FSM IDLE -> BROADCAST -> COLLECT -> RESPOND -> IDLE. Each state lasts exactly one cycle, except IDLE, which waits for an eligible requester.
- IDLE: on an edge with any eligible requester, pick the winner by round-robin. The search starts at the pointer and wraps at NUM_CORES-1 -> 0. Latch cmd/addr/index; go BROADCAST. Set pointer = (winner+1) mod NUM_CORES.
- BROADCAST (k+1): req_ready[winner]=1, snoop_valid=1, snoop_cmd/addr/src = latched values. The requester deasserts or changes req_valid from k+2.
- COLLECT (k+2): snoopers drive snoop_hit/snoop_dirty. Sample at end of cycle with the requester's own bits masked to 0.
- RESPOND (k+3): resp_valid[src]=1.
  - resp_flush = OR(masked dirty).
  - resp_shared = OR(masked hit) for BusRd; forced 0 for BusRdX and BusUpgr.
- Latency: request sampled at edge k -> response at cycle k+3. Next request can be sampled at the end of the IDLE cycle k+4. Peak throughput is 1 transaction per 4 cycles.
- protocol_err pulses during RESPOND if either condition holds on the masked bits; the response is still issued:
  - more than one dirty bit set;
  - dirty[i] && !hit[i] for any i.
- snoop_hit/snoop_dirty are ignored outside the COLLECT cycle.
- A change in the requester's req_valid/cmd/addr after grant does not affect the in-flight transaction.
- Reset mid-operation (any state): next cycle IDLE, all outputs 0, pointer 0. The pending transaction is dropped with no resp_valid; the requester must re-issue.
- NUM_CORES a power of two or not: wrap is an explicit compare, not a bit truncation.

Decomposition:
- mesi_types package: existing bus_request and cache_state enums; add typedef snoop_bus_state_e {IDLE, BROADCAST, COLLECT, RESPOND}.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs clk, rst, req[N], advance;
  - outputs grant_onehot[N], grant_idx, any.
  - It owns the priority pointer, which updates only when advance=1.

Test Plan:
1. Reset held 3 cycles with random inputs -> all outputs 0, snoop_cmd=No_OP, busy=0.
2. NUM_CORES=4. Core 2 issues BusRd 0x3C, no hits -> req_ready=0100 at k+1, snoop (BusRd, 0x3C, src 2), resp_valid=0100 at k+3, shared=0, flush=0.
3. After reset, cores 0, 1, 3 request continuously with BusRd -> grant order 0, 1, 3, 0, 1, 3. Each grant is spaced 4 cycles apart.
4. Core 1 BusRd 0x10 with core 0 hit+dirty -> shared=1, flush=1. Core 1 BusRdX 0x10 with core 2 hit only -> shared=0, flush=0.
5. Core 3 BusRd with snoop_hit=1000 (self only) -> shared=0. Cores 0 and 2 both dirty+hit -> protocol_err pulse at k+3, flush=1.
6. rst asserted during COLLECT -> next cycle busy=0, no resp_valid. A new request from core 3 with core 0 also requesting -> core 0 granted first.
